// File: rtl/load_use_hazard_unit_pkg.sv
// Shared CPU pipeline definitions used by the load-use hazard unit:
// register-address width, the hard-wired zero register, the hazard
// controller FSM encoding and a bundle type for the pipeline control lines.
package load_use_hazard_unit_pkg;

  localparam int                    REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;

  // Hazard controller states.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BUBBLE   = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  // Per-stage hold/bubble controls driven into the pipeline registers.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_bubble;
    logic ex_mem_stall;
    logic mem_wb_stall;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NONE   = '{default: 1'b0};
  // Load-use hazard: hold the front end and push a NOP into EX.
  localparam pipe_ctrl_t CTRL_HAZARD = '{pc_stall: 1'b1, if_id_stall: 1'b1,
                                         id_ex_bubble: 1'b1, ex_mem_stall: 1'b0,
                                         mem_wb_stall: 1'b0};
  // Data memory busy: hold every stage; nothing new enters EX, so no bubble.
  localparam pipe_ctrl_t CTRL_FREEZE = '{pc_stall: 1'b1, if_id_stall: 1'b1,
                                         id_ex_bubble: 1'b0, ex_mem_stall: 1'b1,
                                         mem_wb_stall: 1'b1};

  // A load in EX whose rd feeds the ID instruction. The store-data operand
  // (rs2 of a store) is exempt because MEM-stage forwarding covers it one
  // cycle later; the store address base (rs1) is not exempt.
  function automatic logic load_use_hazard(
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  uses_rs1,
    input logic                  uses_rs2,
    input logic                  is_store,
    input logic [REG_ADDR_W-1:0] rd,
    input logic                  is_load
  );
    logic rs1_dep;
    logic rs2_dep;
    rs1_dep = uses_rs1 && (rs1 == rd);
    rs2_dep = uses_rs2 && (rs2 == rd) && !is_store;
    return is_load && (rd != REG_ZERO) && (rs1_dep || rs2_dep);
  endfunction

endpackage

// File: rtl/load_use_hazard_unit_stall_stat_counter.sv
// Saturating event counter with enable and synchronous active-low clear.
// Holds at all-ones instead of wrapping so long runs never under-report.
module stall_stat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: step by one when enabled and not yet saturated.
  always_comb begin
    count_d = count_q;
    if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/load_use_hazard_unit.sv
// Load-use stall/bubble controller for the 5-stage pipeline.
// Freezes PC and IF/ID and bubbles ID/EX for one cycle when a load in EX
// produces a register the ID instruction needs, freezes the whole pipeline
// while data memory is busy, flags over-long busy periods and keeps
// saturating stall/bubble statistics.
module load_use_hazard_unit
  import load_use_hazard_unit_pkg::*;
#(
  parameter int COUNT_WIDTH  = 32,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [4:0]             REG_READ_ADDR1_S2,
  input  logic [4:0]             REG_READ_ADDR2_S2,
  input  logic                   USES_RS1_S2,
  input  logic                   USES_RS2_S2,
  input  logic                   STAGE_2_MEM_WRITE,
  input  logic [4:0]             STAGE3_REG_ADDR,
  input  logic                   STAGE_3_MEM_READ,
  input  logic                   BRANCH_FLUSH,
  input  logic                   DATA_MEM_BUSY,
  output logic                   PC_STALL,
  output logic                   IF_ID_STALL,
  output logic                   ID_EX_BUBBLE,
  output logic                   EX_MEM_STALL,
  output logic                   MEM_WB_STALL,
  output logic                   MEM_TIMEOUT,
  output logic [COUNT_WIDTH-1:0] STALL_CYCLES,
  output logic [COUNT_WIDTH-1:0] BUBBLE_COUNT
);

  // Wide enough to hold BUSY_TIMEOUT itself.
  localparam int                BUSY_W     = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [BUSY_W-1:0] BUSY_LIMIT = BUSY_W'(BUSY_TIMEOUT);

  hz_state_e         state_q;
  hz_state_e         state_d;
  logic [BUSY_W-1:0] busy_run_q;
  logic [BUSY_W-1:0] busy_run_d;
  logic              mem_timeout_q;
  logic              mem_timeout_d;
  logic              hz;
  pipe_ctrl_t        ctrl;

  // Raw hazard term; whether it acts depends on state, busy and flush.
  assign hz = load_use_hazard(REG_READ_ADDR1_S2, REG_READ_ADDR2_S2,
                              USES_RS1_S2, USES_RS2_S2, STAGE_2_MEM_WRITE,
                              STAGE3_REG_ADDR, STAGE_3_MEM_READ);

  // Next state and same-cycle pipeline controls, busy > flush > hazard.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the if/case can leave one unassigned and infer a latch.
    ctrl    = CTRL_NONE;
    state_d = ST_RUN;
    if (!RESET_N) begin
      // Controls stay quiet while reset is held, whatever the inputs do.
      ctrl    = CTRL_NONE;
      state_d = ST_RUN;
    end else if (DATA_MEM_BUSY) begin
      ctrl    = CTRL_FREEZE;
      state_d = ST_MEM_WAIT;
    end else if (BRANCH_FLUSH) begin
      // The ID instruction is being killed, so its dependency is moot.
      ctrl    = CTRL_NONE;
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        // Leaving MEM_WAIT behaves like RUN: the stages have just moved,
        // so the hazard is judged against the freshly unfrozen contents.
        ST_RUN, ST_MEM_WAIT: begin
          if (hz) begin
            ctrl    = CTRL_HAZARD;
            state_d = ST_BUBBLE;
          end else begin
            state_d = ST_RUN;
          end
        end
        // The bubble has gone in; the load is now in MEM and forwarding
        // handles the consumer, so do not bubble the same pair twice.
        ST_BUBBLE: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // Length of the current busy run (saturating) and sticky timeout flag.
  always_comb begin
    busy_run_d = '0;
    if (DATA_MEM_BUSY) begin
      busy_run_d = (busy_run_q == BUSY_LIMIT) ? busy_run_q
                                              : busy_run_q + BUSY_W'(1);
    end
    mem_timeout_d = mem_timeout_q || (busy_run_d == BUSY_LIMIT);
  end

  // FSM, busy-run and timeout registers with synchronous reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values and ordering between blocks cannot race.
    if (!RESET_N) begin
      state_q       <= ST_RUN;
      busy_run_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_run_q    <= busy_run_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  stall_stat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_stall_cycles (
    .clk     (CLK),
    .clear_n (RESET_N),
    .en      (ctrl.pc_stall),
    .count   (STALL_CYCLES)
  );

  stall_stat_counter #(
    .WIDTH (COUNT_WIDTH)
  ) u_bubble_count (
    .clk     (CLK),
    .clear_n (RESET_N),
    .en      (ctrl.id_ex_bubble),
    .count   (BUBBLE_COUNT)
  );

  assign PC_STALL     = ctrl.pc_stall;
  assign IF_ID_STALL  = ctrl.if_id_stall;
  assign ID_EX_BUBBLE = ctrl.id_ex_bubble;
  assign EX_MEM_STALL = ctrl.ex_mem_stall;
  assign MEM_WB_STALL = ctrl.mem_wb_stall;
  assign MEM_TIMEOUT  = mem_timeout_q;

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Directed bench for load_use_hazard_unit, built with small counters and a
// short busy timeout so saturation and timeout are reachable quickly.
module tb_load_use_hazard_unit;

  localparam int CW       = 3;
  localparam int TMO      = 4;
  localparam int SAT      = (1 << CW) - 1;
  localparam int O_NONE   = 0;
  localparam int O_HZ     = 1;
  localparam int O_FRZ    = 2;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [4:0]    REG_READ_ADDR1_S2, REG_READ_ADDR2_S2, STAGE3_REG_ADDR;
  logic          USES_RS1_S2, USES_RS2_S2, STAGE_2_MEM_WRITE;
  logic          STAGE_3_MEM_READ, BRANCH_FLUSH, DATA_MEM_BUSY;
  logic          PC_STALL, IF_ID_STALL, ID_EX_BUBBLE, EX_MEM_STALL, MEM_WB_STALL;
  logic          MEM_TIMEOUT;
  logic [CW-1:0] STALL_CYCLES, BUBBLE_COUNT;

  load_use_hazard_unit #(
    .COUNT_WIDTH  (CW),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .REG_READ_ADDR1_S2 (REG_READ_ADDR1_S2),
    .REG_READ_ADDR2_S2 (REG_READ_ADDR2_S2),
    .USES_RS1_S2       (USES_RS1_S2),
    .USES_RS2_S2       (USES_RS2_S2),
    .STAGE_2_MEM_WRITE (STAGE_2_MEM_WRITE),
    .STAGE3_REG_ADDR   (STAGE3_REG_ADDR),
    .STAGE_3_MEM_READ  (STAGE_3_MEM_READ),
    .BRANCH_FLUSH      (BRANCH_FLUSH),
    .DATA_MEM_BUSY     (DATA_MEM_BUSY),
    .PC_STALL          (PC_STALL),
    .IF_ID_STALL       (IF_ID_STALL),
    .ID_EX_BUBBLE      (ID_EX_BUBBLE),
    .EX_MEM_STALL      (EX_MEM_STALL),
    .MEM_WB_STALL      (MEM_WB_STALL),
    .MEM_TIMEOUT       (MEM_TIMEOUT),
    .STALL_CYCLES      (STALL_CYCLES),
    .BUBBLE_COUNT      (BUBBLE_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic     pc, ifid, idex, exmem, memwb, tmo;
    int       sc, bc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;
  // Expected counter/flag state as of the most recent clock edge.
  int   sc_m = 0, bc_m = 0, run_m = 0;
  logic tmo_m = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL step%0d %s observed=%0d expected=%0d", step_no, tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, queue the expectation,
  // check mid-cycle, then advance the expected counters across the next edge.
  task automatic step(input logic rstn, input logic busy, input logic fl,
                      input logic ld, input logic [4:0] rd,
                      input logic u1, input logic [4:0] rs1,
                      input logic u2, input logic [4:0] rs2,
                      input logic st, input int outs);
    exp_t e;
    exp_t p;
    @(negedge CLK);
    step_no++;
    RESET_N           = rstn;
    DATA_MEM_BUSY     = busy;
    BRANCH_FLUSH      = fl;
    STAGE_3_MEM_READ  = ld;
    STAGE3_REG_ADDR   = rd;
    USES_RS1_S2       = u1;
    REG_READ_ADDR1_S2 = rs1;
    USES_RS2_S2       = u2;
    REG_READ_ADDR2_S2 = rs2;
    STAGE_2_MEM_WRITE = st;
    e.pc    = (outs != O_NONE);
    e.ifid  = (outs != O_NONE);
    e.idex  = (outs == O_HZ);
    e.exmem = (outs == O_FRZ);
    e.memwb = (outs == O_FRZ);
    e.tmo   = tmo_m;
    e.sc    = sc_m;
    e.bc    = bc_m;
    sb_q.push_back(e);
    #1;
    p = sb_q.pop_front();
    chk("pc_stall",     int'(PC_STALL),     int'(p.pc));
    chk("if_id_stall",  int'(IF_ID_STALL),  int'(p.ifid));
    chk("id_ex_bubble", int'(ID_EX_BUBBLE), int'(p.idex));
    chk("ex_mem_stall", int'(EX_MEM_STALL), int'(p.exmem));
    chk("mem_wb_stall", int'(MEM_WB_STALL), int'(p.memwb));
    chk("mem_timeout",  int'(MEM_TIMEOUT),  int'(p.tmo));
    chk("stall_cycles", int'(STALL_CYCLES), p.sc);
    chk("bubble_count", int'(BUBBLE_COUNT), p.bc);
    if (!rstn) begin
      sc_m = 0; bc_m = 0; run_m = 0; tmo_m = 1'b0;
    end else begin
      if (e.pc && sc_m < SAT) sc_m++;
      if (e.idex && bc_m < SAT) bc_m++;
      run_m = busy ? ((run_m < TMO) ? run_m + 1 : run_m) : 0;
      if (run_m == TMO) tmo_m = 1'b1;
    end
  endtask

  // Load rd=x5 in EX, ADD in ID reading rs1=x5.
  task automatic hz5(input logic rstn, input logic busy, input logic fl, input int outs);
    step(rstn, busy, fl, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, outs);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, O_NONE);
  endtask

  initial begin
    RESET_N = 1'b0; DATA_MEM_BUSY = 1'b0; BRANCH_FLUSH = 1'b0;
    STAGE_3_MEM_READ = 1'b0; STAGE3_REG_ADDR = '0; USES_RS1_S2 = 1'b0;
    REG_READ_ADDR1_S2 = '0; USES_RS2_S2 = 1'b0; REG_READ_ADDR2_S2 = '0;
    STAGE_2_MEM_WRITE = 1'b0;
    repeat (2) @(posedge CLK);

    // Reset held with busy and a hazard present: controls stay 0.
    hz5(1'b0, 1'b1, 1'b0, O_NONE);
    hz5(1'b0, 1'b0, 1'b0, O_NONE);

    // Basic load-use on rs1: one bubble, then quiet; counters 1/1.
    hz5(1'b1, 1'b0, 1'b0, O_HZ);
    hz5(1'b1, 1'b0, 1'b0, O_NONE);
    idle();

    // Store data dependency (rs2) is exempt; store base (rs1) is not.
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, O_NONE);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, O_HZ);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, O_NONE);
    idle();

    // Load to x0 never stalls; flush suppresses and keeps RUN.
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, O_NONE);
    hz5(1'b1, 1'b0, 1'b1, O_NONE);
    hz5(1'b1, 1'b0, 1'b0, O_HZ);
    hz5(1'b1, 1'b0, 1'b0, O_NONE);
    // Non-store rs2 dependency stalls; unused rs1 match does not.
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, O_HZ);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, O_NONE);
    step(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, O_NONE);
    idle();

    // Busy 3 cycles with hazard pending, then bubble as busy drops: 4/1.
    hz5(1'b0, 1'b0, 1'b0, O_NONE);
    hz5(1'b1, 1'b1, 1'b0, O_FRZ);
    hz5(1'b1, 1'b1, 1'b0, O_FRZ);
    hz5(1'b1, 1'b1, 1'b1, O_FRZ);
    hz5(1'b1, 1'b0, 1'b0, O_HZ);
    hz5(1'b1, 1'b0, 1'b0, O_NONE);
    idle();

    // Busy 6 cycles: timeout after the 4th, sticky afterwards; counters saturate.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, logic'(i[0]), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, O_FRZ);
    end
    idle();
    idle();
    hz5(1'b1, 1'b0, 1'b0, O_HZ);
    hz5(1'b1, 1'b0, 1'b0, O_NONE);
    idle();

    // Reset taken from BUBBLE: next hazard bubbles immediately; timeout cleared.
    hz5(1'b1, 1'b0, 1'b0, O_HZ);
    hz5(1'b0, 1'b0, 1'b0, O_NONE);
    hz5(1'b1, 1'b0, 1'b0, O_HZ);
    hz5(1'b1, 1'b0, 1'b0, O_NONE);
    idle();

    // Nine hazard/bubble pairs: both counters pin at all-ones.
    for (int i = 0; i < 9; i++) begin
      hz5(1'b1, 1'b0, 1'b0, O_HZ);
      hz5(1'b1, 1'b0, 1'b0, O_NONE);
    end
    idle();

    // Reset in the middle of MEM_WAIT: back to RUN with counters cleared.
    hz5(1'b1, 1'b1, 1'b0, O_FRZ);
    hz5(1'b1, 1'b1, 1'b0, O_FRZ);
    hz5(1'b0, 1'b1, 1'b0, O_NONE);
    idle();
    hz5(1'b1, 1'b0, 1'b0, O_HZ);
    idle();

    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
